// File: rtl/sequence_detector.sv
// Serial matcher for the fixed 3-bit symbol pattern 001,101,110,000,110,110,011,101.
// Raises a registered one-cycle pulse after the eighth consecutive matching symbol.
module sequence_detector (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] data,
   output logic       sequence_found
);

   typedef enum logic [3:0] {
      St0, St1, St2, St3, St4, St5, St6, St7, StFound
   } state_e;

   localparam logic [2:0] Sym0 = 3'b001;
   localparam logic [2:0] Sym1 = 3'b101;
   localparam logic [2:0] Sym2 = 3'b110;
   localparam logic [2:0] Sym3 = 3'b000;
   localparam logic [2:0] Sym4 = 3'b110;
   localparam logic [2:0] Sym5 = 3'b110;
   localparam logic [2:0] Sym6 = 3'b011;
   localparam logic [2:0] Sym7 = 3'b101;

   state_e state_q, state_d;
   logic   found_q, found_d;

   // 001 appears only at the head of the pattern, so a mismatch on 001 restarts at St1.
   function automatic state_e advance(input logic [2:0] sym, input logic [2:0] want,
                                      input state_e on_match);
      if (sym == want) begin
         return on_match;
      end else if (sym == Sym0) begin
         return St1;
      end else begin
         return St0;
      end
   endfunction

   always_comb begin
      state_d = St0;
      case (state_q)
         St0:     state_d = advance(data, Sym0, St1);
         St1:     state_d = advance(data, Sym1, St2);
         St2:     state_d = advance(data, Sym2, St3);
         St3:     state_d = advance(data, Sym3, St4);
         St4:     state_d = advance(data, Sym4, St5);
         St5:     state_d = advance(data, Sym5, St6);
         St6:     state_d = advance(data, Sym6, St7);
         St7:     state_d = advance(data, Sym7, StFound);
         StFound: state_d = (data == Sym0) ? St1 : St0;
         default: state_d = St0;
      endcase
   end

   assign found_d = (state_d == StFound);

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q <= St0;
         found_q <= 1'b0;
      end else begin
         state_q <= state_d;
         found_q <= found_d;
      end
   end

   assign sequence_found = found_q;

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: match pulse, abort, back-to-back, reset and restart.
module tb_sequence_detector;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] data;
   logic       sequence_found;

   int checks = 0;
   int errors = 0;

   logic [2:0] pat [0:7];

   sequence_detector dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .data           (data),
      .sequence_found (sequence_found)
   );

   always #5 clk = ~clk;

   // Drive on the falling edge, then sample just after the following rising edge.
   task automatic send(input logic [2:0] sym);
      @(negedge clk);
      data = sym;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      data    = 3'b001;
      #1;
      checks++;
      if (sequence_found !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got %b expected 0", sequence_found);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sequence_found !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got %b expected 0", sequence_found);
      end
      @(negedge clk);
      reset_n = 1'b0;
      data    = 3'b000;
   endtask

   task automatic test_single();
      for (int i = 0; i < 8; i++) begin
         send(pat[i]);
         checks++;
         if (sequence_found !== (i == 7)) begin
            errors++;
            $display("FAIL single sym%0d: got %b expected %b", i, sequence_found, (i == 7));
         end
      end
   endtask

   task automatic test_drop();
      send(3'b000);
      checks++;
      if (sequence_found !== 1'b0) begin
         errors++;
         $display("FAIL drop_after_pulse: got %b expected 0", sequence_found);
      end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 7; i++) begin
         send(pat[i]);
         checks++;
         if (sequence_found !== 1'b0) begin
            errors++;
            $display("FAIL abort prefix sym%0d: got %b expected 0", i, sequence_found);
         end
      end
      send(3'b000);
      checks++;
      if (sequence_found !== 1'b0) begin
         errors++;
         $display("FAIL abort wrong_last: got %b expected 0", sequence_found);
      end
      // A non-001 mismatch mid-pattern must fall back to the idle state.
      send(3'b001);
      send(3'b101);
      send(3'b111);
      for (int i = 2; i < 8; i++) begin
         send(pat[i]);
         checks++;
         if (sequence_found !== 1'b0) begin
            errors++;
            $display("FAIL abort mid sym%0d: got %b expected 0", i, sequence_found);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         send(pat[i % 8]);
         checks++;
         if (sequence_found !== (i == 7 || i == 15)) begin
            errors++;
            $display("FAIL back_to_back sym%0d: got %b expected %b", i, sequence_found,
                     (i == 7 || i == 15));
         end
      end
   endtask

   task automatic test_reset_during();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(pat[i]);
         checks++;
         if (sequence_found !== 1'b0) begin
            errors++;
            $display("FAIL reset_held sym%0d: got %b expected 0", i, sequence_found);
         end
      end
      @(negedge clk);
      reset_n = 1'b0;
      data    = 3'b000;
      for (int i = 0; i < 8; i++) send(pat[i]);
      checks++;
      if (sequence_found !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_pulse: got %b expected 1", sequence_found);
      end
      #2;
      reset_n = 1'b1;
      #1;
      checks++;
      if (sequence_found !== 1'b0) begin
         errors++;
         $display("FAIL reset_clears_pulse: got %b expected 0", sequence_found);
      end
      @(negedge clk);
      reset_n = 1'b0;
      data    = 3'b000;
   endtask

   task automatic test_restart();
      logic [2:0] seq [0:9];
      seq = '{3'b001, 3'b101, 3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110,
              3'b011, 3'b101};
      for (int i = 0; i < 10; i++) begin
         send(seq[i]);
         checks++;
         if (sequence_found !== (i == 9)) begin
            errors++;
            $display("FAIL restart sym%0d: got %b expected %b", i, sequence_found, (i == 9));
         end
      end
      send(3'b000);
      checks++;
      if (sequence_found !== 1'b0) begin
         errors++;
         $display("FAIL restart_drop: got %b expected 0", sequence_found);
      end
   endtask

   initial begin
      pat = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
      test_reset();
      test_single();
      test_drop();
      test_abort();
      test_back_to_back();
      test_reset_during();
      test_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
